// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: fetch handshake, redirect/trap/mret events
// and the PC/EPC/badaddr state exported to fetch and CSR logic.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_valid_o;
  logic                  fetch_ready_i;
  logic                  compressed_i;
  logic                  stall_i;
  logic                  redirect_valid_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic [ADDR_WIDTH-1:0] redirect_src_i;
  logic                  trap_i;
  logic [ADDR_WIDTH-1:0] trap_pc_i;
  logic                  mret_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [ADDR_WIDTH-1:0] epc_o;
  logic [ADDR_WIDTH-1:0] badaddr_o;
  logic                  misalign_o;

  // PC generator side
  modport master (
    input  fetch_ready_i, compressed_i, stall_i, redirect_valid_i,
           redirect_pc_i, redirect_src_i, trap_i, trap_pc_i, mret_i,
    output fetch_valid_o, pc_o, epc_o, badaddr_o, misalign_o
  );

  // Fetch / pipeline / CSR side
  modport slave (
    output fetch_ready_i, compressed_i, stall_i, redirect_valid_i,
           redirect_pc_i, redirect_src_i, trap_i, trap_pc_i, mret_i,
    input  fetch_valid_o, pc_o, epc_o, badaddr_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance under the fetch
// handshake, redirects, trap entry (external or misaligned target) and mret.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 'h100,
  parameter bit                    C_EXT        = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  pc_gen_if.master  bus
);

  typedef enum logic {BOOT, RUN} state_e;

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    C_EXT ? ADDR_WIDTH'(1) : ADDR_WIDTH'(3);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [ADDR_WIDTH-1:0] bad_q, bad_d;
  logic                  mis_q, mis_d;
  logic                  tgt_misaligned;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign tgt_misaligned = |(bus.redirect_pc_i & ALIGN_MASK);
  assign pc_inc = (C_EXT && bus.compressed_i) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);

  // State register: one BOOT cycle after reset, then RUN forever.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= BOOT;
    else          state_q <= state_d;
  end

  // Next-state and next-PC selection; events are ignored during BOOT.
  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    mis_d   = 1'b0;
    if (state_q == RUN) begin
      if (bus.trap_i) begin
        pc_d  = TRAP_VECTOR;
        epc_d = bus.trap_pc_i & ~ALIGN_MASK;
      end else if (bus.mret_i) begin
        pc_d = epc_q;
      end else if (bus.redirect_valid_i && !tgt_misaligned) begin
        pc_d = bus.redirect_pc_i;
      end else if (bus.redirect_valid_i) begin
        // Misaligned target traps; EPC points at the offending branch.
        pc_d  = TRAP_VECTOR;
        epc_d = bus.redirect_src_i;
        bad_d = bus.redirect_pc_i;
        mis_d = 1'b1;
      end else if (!bus.stall_i && bus.fetch_ready_i) begin
        pc_d = pc_q + pc_inc;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      bad_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      bad_q <= bad_d;
      mis_q <= mis_d;
    end
  end

  assign bus.fetch_valid_o = (state_q == RUN);
  assign bus.pc_o          = pc_q;
  assign bus.epc_o         = epc_q;
  assign bus.badaddr_o     = bad_q;
  assign bus.misalign_o    = mis_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch stage, replacing the bare PC register. It owns the architectural fetch PC, advances it sequentially under a fetch handshake, and applies branch/jump redirects, trap entry (external or internally detected misaligned target) and `mret` return. It holds a saved exception PC and a faulting-address register for the CSR/trap logic.

## Interface
- `ADDR_WIDTH`, 32: PC width in bits (≥ 8).
- `RESET_VECTOR`, 32'h0000_0000: PC loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on trap entry; must be 4-byte aligned.
- `C_EXT`, 0: 1 enables 2-byte instruction alignment and +2 increments.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `fetch_valid_o` out 1: `pc_o` is a valid fetch request.
- `fetch_ready_i` in 1: instruction memory accepts `pc_o` this cycle.
- `compressed_i` in 1: accepted instruction is 16-bit; ignored when `C_EXT`=0.
- `stall_i` in 1: hold PC; blocks sequential advance only.
- `redirect_valid_i` in 1: branch/jump taken.
- `redirect_pc_i` in ADDR_WIDTH: redirect target.
- `redirect_src_i` in ADDR_WIDTH: PC of the branch/jump instruction.
- `trap_i` in 1: external exception/interrupt entry.
- `trap_pc_i` in ADDR_WIDTH: PC to save on `trap_i`.
- `mret_i` in 1: return from trap.
- `pc_o` out ADDR_WIDTH: current fetch PC.
- `epc_o` out ADDR_WIDTH: saved exception PC.
- `badaddr_o` out ADDR_WIDTH: last misaligned target.
- `misalign_o` out 1: one-cycle pulse, misaligned redirect trapped.

## Operation
- FSM: BOOT, RUN. Reset → BOOT. BOOT → RUN unconditionally after one clock. No other transitions except reset.
- BOOT: `fetch_valid_o`=0; all event inputs ignored; `pc_o` holds RESET_VECTOR.
- RUN: `fetch_valid_o`=1. Next-PC selection per cycle, strict priority:
  1. `trap_i`: pc ← TRAP_VECTOR; epc ← `trap_pc_i` with alignment bits cleared (bit0; also bit1 when `C_EXT`=0).
  2. `mret_i`: pc ← epc.
  3. `redirect_valid_i` and target aligned: pc ← `redirect_pc_i`.
  4. `redirect_valid_i` and target misaligned (`C_EXT`=0: bits[1:0]≠0; `C_EXT`=1: bit0≠0): pc ← TRAP_VECTOR; epc ← `redirect_src_i`; badaddr ← `redirect_pc_i`; `misalign_o` pulses.
  5. `stall_i`=1 or `fetch_ready_i`=0: hold.
  6. Otherwise (handshake accepted): pc ← pc + 2 if `C_EXT`=1 and `compressed_i`=1, else pc + 4.
- Priorities 1–4 override `stall_i` and `fetch_ready_i`.
- Arithmetic modulo 2^ADDR_WIDTH; increment past all-ones wraps to low addresses, no flag.
- epc and badaddr change only on cases 1/4; `mret_i` does not modify epc.

## Timing
- Reset values (asynchronous): `pc_o`=RESET_VECTOR, `epc_o`=0, `badaddr_o`=0, `misalign_o`=0, `fetch_valid_o`=0, state BOOT.
- All outputs registered; an event sampled at edge N appears on outputs after edge N (one-cycle latency).
- `misalign_o` high exactly one cycle per trapped redirect; back-to-back misaligned redirects give back-to-back pulses.
- `fetch_valid_o` first high in the cycle after the first post-reset edge.
- Simultaneous `trap_i` + `mret_i` + redirect: trap wins, others dropped.
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.

## Test plan
- Reset release, `fetch_ready_i`=1 → `pc_o` 0x0, 0x0 (BOOT, valid=0), then 0x4, 0x8, 0xC with valid=1.
- `fetch_ready_i`=0 for 3 cycles at pc=0x10, then `stall_i`=1 for 2 cycles → `pc_o` holds 0x10 for 5 cycles, then 0x14.
- Redirect to 0x200 while `stall_i`=1 → next `pc_o`=0x200; redirect 0x202 with src 0x40, `C_EXT`=0 → `pc_o`=0x100, `epc_o`=0x40, `badaddr_o`=0x202, one-cycle `misalign_o`.
- `C_EXT`=1: `compressed_i` 1,0,1 from 0x0 → 0x2, 0x6, 0x8; redirect 0x202 accepted; redirect 0x203 traps.
- `trap_i` with `trap_pc_i`=0x5C plus redirect 0x300 same cycle → `pc_o`=0x100, `epc_o`=0x5C; later `mret_i` → `pc_o`=0x5C.
- `ADDR_WIDTH`=16, pc=0xFFFC, accepted fetch → `pc_o`=0x0000; assert `rst_n_i` low mid-cycle → outputs reset without clock edge.
